// File: rtl/mem_ctrl.sv
// mem_ctrl: serves the core's 32-bit instruction-fetch and data ports from a
// single byte-wide synchronous RAM. The data port has priority over the fetch
// port. Each word access is split into four little-endian byte accesses, and
// a one-cycle done pulse marks completion for the port that was served.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port (read only)
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [3:0]        dm_sel,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  // byte-wide RAM
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic [1:0]  cnt;      // byte index currently on ram_addr
  logic        rd_tail;  // extra read cycle that captures lane 3
  logic        port_dm;  // 1 = data port is being served, 0 = fetch port
  logic [2:0]  sel_q;    // lane enables still to be issued, lane 1 first
  logic [23:0] wdata_q;  // write bytes still to be issued, lane 1 first
  logic [23:0] rd_buf;   // lanes 0..2 collected so far, newest at the top

  // Address bits above the RAM width are dropped on purpose.
  logic addr_hi_unused;
  assign addr_hi_unused = ^{if_addr[31:ADDR_W], dm_addr[31:ADDR_W]};

  // Busy for the whole access, from acceptance through the done cycle.
  assign busy = (state != IDLE);

  // Arbitration, byte sequencing, read assembly and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      rd_tail  <= 1'b0;
      port_dm  <= 1'b0;
      sel_q    <= '0;
      wdata_q  <= '0;
      rd_buf   <= '0;
      if_data  <= '0;
      dm_rdata <= '0;
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      ram_addr <= '0;
      ram_we   <= 1'b0;
      ram_din  <= '0;
    end else begin
      // NOTE: pulse outputs get a non-blocking default here and are raised
      // only in the branch that needs them, so no path can leave them stuck.
      if_done <= 1'b0;
      dm_done <= 1'b0;
      ram_we  <= 1'b0;

      case (state)
        IDLE: begin
          if (dm_req) begin
            port_dm  <= 1'b1;
            cnt      <= 2'd0;
            rd_tail  <= 1'b0;
            ram_addr <= dm_addr[ADDR_W-1:0];
            ram_din  <= dm_wdata[7:0];
            wdata_q  <= dm_wdata[31:8];
            sel_q    <= dm_sel[3:1];
            if (dm_we) begin
              ram_we <= dm_sel[0];
              state  <= WR;
            end else begin
              state  <= RD;
            end
          end else if (if_req) begin
            port_dm  <= 1'b0;
            cnt      <= 2'd0;
            rd_tail  <= 1'b0;
            ram_addr <= if_addr[ADDR_W-1:0];
            state    <= RD;
          end
        end

        RD: begin
          if (rd_tail) begin
            // Lane 3 arrives now; publish the whole word to the served port.
            if (port_dm) begin
              dm_rdata <= {ram_dout, rd_buf};
              dm_done  <= 1'b1;
            end else begin
              if_data  <= {ram_dout, rd_buf};
              if_done  <= 1'b1;
            end
            rd_tail <= 1'b0;
            state   <= DONE;
          end else begin
            // ram_dout holds the byte addressed one cycle earlier.
            if (cnt != 2'd0) rd_buf <= {ram_dout, rd_buf[23:8]};
            if (cnt == 2'd3) rd_tail  <= 1'b1;
            else             ram_addr <= ram_addr + ADDR_W'(1);
            cnt <= cnt + 2'd1;
          end
        end

        WR: begin
          if (cnt == 2'd3) begin
            cnt     <= 2'd0;
            dm_done <= 1'b1;
            state   <= DONE;
          end else begin
            // Every lane takes its cycle; unselected lanes carry no strobe.
            ram_addr <= ram_addr + ADDR_W'(1);
            ram_we   <= sel_q[0];
            ram_din  <= wdata_q[7:0];
            sel_q    <= {1'b0, sel_q[2:1]};
            wdata_q  <= {8'h00, wdata_q[23:8]};
            cnt      <= cnt + 2'd1;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte RAM model on the RAM side, a word-level
// reference memory, and per-scenario tasks with cycle-exact expectations.
module tb_mem_ctrl;

  localparam int AW       = 17;
  localparam int MEM_SIZE = 1 << AW;
  localparam logic [31:0] MASK = 32'(MEM_SIZE - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic [31:0]   if_data;
  logic          if_done;
  logic          dm_req;
  logic          dm_we;
  logic [31:0]   dm_addr;
  logic [3:0]    dm_sel;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;
  logic          dm_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_din;
  logic [7:0]    ram_dout;
  logic          busy;

  // Backdoor into the RAM for preloading.
  logic          bd_clr;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [7:0]    bd_data;

  logic [7:0] mem   [0:MEM_SIZE-1];  // the physical RAM seen by the DUT
  logic [7:0] model [0:MEM_SIZE-1];  // expected memory contents

  logic [31:0] exp_if_data;
  logic [31:0] exp_dm_rdata;
  int n_checks = 0;
  int n_errors = 0;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_sel(dm_sel),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous single-port byte RAM, read data one cycle after the address.
  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= 8'h00;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  function automatic int wrap_idx(input logic [31:0] addr, input int k);
    return int'((addr + 32'(k)) & MASK);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = model[wrap_idx(addr, k)];
    return w;
  endfunction

  // Preload one RAM byte while the controller is idle.
  task automatic poke(input logic [31:0] addr, input logic [7:0] data);
    bd_we   = 1'b1;
    bd_addr = AW'(addr & MASK);
    bd_data = data;
    @(posedge clk); #1;
    bd_we = 1'b0;
    model[wrap_idx(addr, 0)] = data;
  endtask

  // One complete access on one port, entered just after a rising edge with
  // the controller idle (or about to sample a held request). Cycle k is the
  // k-th cycle after the accepting edge.
  task automatic do_access(input bit dm, input bit we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] wdata,
                           input bit hold);
    bit          is_wr;
    int          last;
    logic [31:0] word;
    is_wr = dm && we;
    last  = is_wr ? 5 : 6;
    word  = model_word(addr);
    if (dm) begin
      dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_sel = sel; dm_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int k = 1; k <= last; k++) begin
      @(posedge clk);
      if (k == 2) begin
        #1;
        // Inputs changed after acceptance must have no effect.
        if (dm) begin
          dm_addr = $urandom; dm_wdata = $urandom; dm_sel = 4'($urandom); dm_we = ~we;
        end else begin
          if_addr = $urandom;
        end
      end
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
        n_errors++; $display("FAIL busy cycle %0d: got %b want 1", k, busy);
      end
      if (k <= 4) begin
        n_checks++;
        if (ram_addr !== AW'(wrap_idx(addr, k - 1))) begin
          n_errors++;
          $display("FAIL ram_addr cycle %0d: got %h want %h", k, ram_addr, AW'(wrap_idx(addr, k - 1)));
        end
        n_checks++;
        if (ram_we !== (is_wr ? sel[k-1] : 1'b0)) begin
          n_errors++;
          $display("FAIL ram_we cycle %0d: got %b want %b", k, ram_we, is_wr ? sel[k-1] : 1'b0);
        end
        if (is_wr && sel[k-1]) begin
          n_checks++;
          if (ram_din !== wdata[8*(k-1) +: 8]) begin
            n_errors++;
            $display("FAIL ram_din cycle %0d: got %h want %h", k, ram_din, wdata[8*(k-1) +: 8]);
          end
        end
      end else begin
        n_checks++;
        if (ram_we !== 1'b0) begin
          n_errors++; $display("FAIL ram_we cycle %0d: got %b want 0", k, ram_we);
        end
      end
      n_checks++;
      if (if_done !== (!dm && k == last)) begin
        n_errors++; $display("FAIL if_done cycle %0d: got %b want %b", k, if_done, !dm && k == last);
      end
      n_checks++;
      if (dm_done !== (dm && k == last)) begin
        n_errors++; $display("FAIL dm_done cycle %0d: got %b want %b", k, dm_done, dm && k == last);
      end
      if (k == last && !is_wr) begin
        if (dm) exp_dm_rdata = word;
        else    exp_if_data  = word;
      end
      n_checks++;
      if (if_data !== exp_if_data) begin
        n_errors++; $display("FAIL if_data cycle %0d: got %h want %h", k, if_data, exp_if_data);
      end
      n_checks++;
      if (dm_rdata !== exp_dm_rdata) begin
        n_errors++; $display("FAIL dm_rdata cycle %0d: got %h want %h", k, dm_rdata, exp_dm_rdata);
      end
      if (k == last && !hold) begin
        if (dm) dm_req = 1'b0;
        else    if_req = 1'b0;
      end
    end
    if (is_wr) begin
      for (int k = 0; k < 4; k++)
        if (sel[k]) model[wrap_idx(addr, k)] = wdata[8*k +: 8];
    end
    @(posedge clk); #1;
  endtask

  // Requests low: controller must stay idle with no done pulses.
  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, if_done, dm_done, ram_we} !== 4'b0000) begin
        n_errors++;
        $display("FAIL idle cycle %0d: busy/if_done/dm_done/ram_we got %b want 0000",
                 i, {busy, if_done, dm_done, ram_we});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_sel = '0; dm_wdata = '0;
    bd_clr = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < MEM_SIZE; i++) model[i] = 8'h00;
    exp_if_data = '0; exp_dm_rdata = '0;
    repeat (3) @(posedge clk);
    bd_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, if_done, dm_done, if_data, dm_rdata, ram_addr, ram_we, ram_din} !== '0) begin
      n_errors++;
      $display("FAIL reset outputs: busy=%b if_done=%b dm_done=%b if_data=%h dm_rdata=%h ram_addr=%h ram_we=%b ram_din=%h, want all 0",
               busy, if_done, dm_done, if_data, dm_rdata, ram_addr, ram_we, ram_din);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    idle_check(2);
  endtask

  task automatic test_fetch();
    poke(32'h10, 8'h93); poke(32'h11, 8'h00); poke(32'h12, 8'hA0); poke(32'h13, 8'h00);
    do_access(1'b0, 1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
    n_checks++;
    if (if_data !== 32'h00A0_0093) begin
      n_errors++; $display("FAIL fetch word: got %h want 00a00093", if_data);
    end
  endtask

  task automatic test_sparse_write();
    do_access(1'b1, 1'b1, 32'h0000_0100, 4'b0101, 32'hAABB_CCDD, 1'b0);
    do_access(1'b1, 1'b0, 32'h0000_0100, 4'h0, 32'h0, 1'b0);
    n_checks++;
    if (dm_rdata !== 32'h00BB_00DD) begin
      n_errors++; $display("FAIL sparse readback: got %h want 00bb00dd", dm_rdata);
    end
  endtask

  task automatic test_collision();
    poke(32'h200, 8'h78); poke(32'h201, 8'h56); poke(32'h202, 8'h34); poke(32'h203, 8'h12);
    for (int k = 0; k < 4; k++) poke(32'(k), 8'($urandom));
    if_req  = 1'b1;
    if_addr = 32'h0;
    do_access(1'b1, 1'b0, 32'h0000_0200, 4'h0, 32'h0, 1'b0);  // data first
    n_checks++;
    if (dm_rdata !== 32'h1234_5678) begin
      n_errors++; $display("FAIL collision data word: got %h want 12345678", dm_rdata);
    end
    do_access(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);          // then fetch
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 4; k++) poke(32'h1FFFE + 32'(k), 8'($urandom_range(1, 255)));
    do_access(1'b1, 1'b0, 32'h0001_FFFE, 4'h0, 32'h0, 1'b0);
    do_access(1'b0, 1'b0, 32'hFFFF_FFFE, 4'h0, 32'h0, 1'b0);
    do_access(1'b1, 1'b1, 32'h0003_FFFF, 4'b1111, $urandom, 1'b0);
    do_access(1'b1, 1'b0, 32'h0001_FFFF, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] wd;
    wd = $urandom;
    for (int k = 0; k < 4; k++) poke(32'h400 + 32'(k), 8'($urandom_range(1, 255)));
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400; dm_sel = 4'b1111; dm_wdata = wd;
    @(posedge clk);                      // accept
    @(negedge clk);                      // WR cycle 1
    n_checks++;
    if (ram_we !== 1'b1) begin
      n_errors++; $display("FAIL midwr cycle1 ram_we: got %b want 1", ram_we);
    end
    @(posedge clk);
    @(negedge clk);                      // WR cycle 2
    n_checks++;
    if (ram_addr !== AW'(32'h401)) begin
      n_errors++; $display("FAIL midwr cycle2 ram_addr: got %h want 00401", ram_addr);
    end
    rst = 1'b1; dm_req = 1'b0;
    @(posedge clk);                      // reset edge, lane 1 strobe lands
    @(negedge clk);
    n_checks++;
    if ({busy, if_done, dm_done, if_data, dm_rdata, ram_addr, ram_we, ram_din} !== '0) begin
      n_errors++;
      $display("FAIL midwr after reset: busy=%b if_done=%b dm_done=%b if_data=%h dm_rdata=%h ram_addr=%h ram_we=%b ram_din=%h, want all 0",
               busy, if_done, dm_done, if_data, dm_rdata, ram_addr, ram_we, ram_din);
    end
    rst = 1'b0;
    exp_if_data = '0; exp_dm_rdata = '0;
    model[32'h400] = wd[7:0];
    model[32'h401] = wd[15:8];
    @(posedge clk); #1;
    idle_check(6);
    do_access(1'b1, 1'b0, 32'h400, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic test_held_request();
    for (int k = 0; k < 4; k++) poke(32'h500 + 32'(k), 8'($urandom));
    do_access(1'b1, 1'b0, 32'h500, 4'h0, 32'h0, 1'b1);   // req held past done
    do_access(1'b1, 1'b0, 32'h500, 4'h0, 32'h0, 1'b0);   // second access, dropped
    idle_check(4);
    do_access(1'b0, 1'b0, 32'h500, 4'h0, 32'h0, 1'b1);
    do_access(1'b0, 1'b0, 32'h500, 4'h0, 32'h0, 1'b0);
    idle_check(3);
  endtask

  task automatic test_back_to_back_random();
    bit          dm;
    bit          we;
    logic [31:0] base;
    logic [31:0] addr;
    for (int i = 0; i < 60; i++) begin
      dm   = ($urandom_range(0, 2) != 0);
      we   = ($urandom_range(0, 1) != 0);
      base = ($urandom_range(0, 7) == 0) ? 32'h1FFF0 : 32'h300;
      addr = ($urandom & ~MASK) | ((base + 32'($urandom_range(0, 31))) & MASK);
      do_access(dm, we, addr, 4'($urandom), $urandom, 1'b0);
      if ($urandom_range(0, 3) == 0) idle_check($urandom_range(1, 2));
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_sparse_write();
    test_collision();
    test_wrap();
    test_reset_mid_write();
    test_held_request();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
